// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
package if_pkg;

    localparam int                ADDR_W     = 32;
    localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd4;
    localparam logic [ADDR_W-1:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: redirect/stall controls, instruction memory port and IF/ID outputs.
interface if_fetch_unit_if;
    import if_pkg::*;

    logic              freeze;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W-1:0] imem_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_instr;
    logic              id_valid;
    logic              halted;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_instr,
        output imem_addr, id_pc, id_instr, id_valid, halted
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_instr,
        input  imem_addr, id_pc, id_instr, id_valid, halted
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush beats hold, hold beats load.
module if_id_reg
    import if_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              hold,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic [ADDR_W-1:0] instr_next,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_instr,
    output logic              id_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (load && !hold) begin
            id_pc    <= pc_next;
            id_instr <= instr_next;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage front end: PC register, next-PC mux, BOOT/RUN/HALT FSM and IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PC_LIMIT = 32'h0000_0018
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_unit_if.master    bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic              halted_reg;
    logic              at_limit;
    logic              ifid_load, ifid_flush, ifid_hold;

    assign pc_plus4 = pc_reg + WORD_BYTES;
    assign at_limit = (pc_reg == PC_LIMIT);

    // BOOT never captures; freeze holds everything unless a branch flushes.
    assign ifid_hold = bus.freeze || (state_reg == BOOT);
    assign ifid_load = (state_reg == RUN) && !at_limit;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ifid_flush = 1'b0;
        if (bus.branch_taken) begin
            pc_next    = word_align(bus.branch_addr);
            state_next = RUN;
            ifid_flush = 1'b1;
        end else begin
            case (state_reg)
                BOOT: state_next = RUN;
                RUN: begin
                    if (!bus.freeze) begin
                        if (at_limit) begin
                            ifid_flush = 1'b1;
                            state_next = HALT;
                        end else begin
                            pc_next = pc_plus4;
                        end
                    end
                end
                HALT:    ifid_flush = !bus.freeze;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= BOOT;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            halted_reg <= (state_next == HALT);
        end
    end

    assign bus.imem_addr = pc_reg;
    assign bus.halted    = halted_reg;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .hold       (ifid_hold),
        .pc_next    (pc_plus4),
        .instr_next (bus.imem_instr),
        .id_pc      (bus.id_pc),
        .id_instr   (bus.id_instr),
        .id_valid   (bus.id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic fetch_fire;
    assign fetch_fire = ifid_load && !ifid_hold && !ifid_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (fetch_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (ifid_flush) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised self-checking bench for if_fetch_unit against a cycle-level behavioural model.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_LIMIT = 32'h0000_0018;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign bus.imem_instr = mem_word(bus.imem_addr);

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC), .PC_LIMIT(PC_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          m_state;
    logic [31:0] m_pc, e_pc, e_instr;
    logic        e_valid;
    logic [31:0] m_fetches, m_bubbles;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = M_BOOT; m_pc = RESET_PC;
        e_pc = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
        m_fetches = 32'h0; m_bubbles = 32'h0;
    endtask

    task automatic model_clock(input logic fz, input logic br, input logic [31:0] ba);
        logic bubble;
        bubble = 1'b0;
        if (br) begin
            m_pc = ba & 32'hFFFF_FFFC; bubble = 1'b1; m_state = M_RUN;
        end else if (m_state == M_BOOT) begin
            m_state = M_RUN;
        end else if (fz) begin
            bubble = 1'b0;
        end else if (m_state == M_HALT) begin
            bubble = 1'b1;
        end else if (m_pc == PC_LIMIT) begin
            bubble = 1'b1; m_state = M_HALT;
        end else begin
            e_instr = mem_word(m_pc);
            e_pc    = m_pc + 32'd4;
            e_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fetches = m_fetches + 32'd1;
        end
        if (bubble) begin
            e_pc = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
            m_bubbles = m_bubbles + 32'd1;
        end
    endtask

    task automatic compare_all(input string ph);
        check_val({ph, ".imem_addr"}, bus.imem_addr, m_pc);
        check_val({ph, ".id_pc"}, bus.id_pc, e_pc);
        check_val({ph, ".id_instr"}, bus.id_instr, e_instr);
        check_val({ph, ".id_valid"}, {31'b0, bus.id_valid}, {31'b0, e_valid});
        check_val({ph, ".halted"}, {31'b0, bus.halted}, {31'b0, (m_state == M_HALT)});
`ifdef IF_PERF_CNT_EN
        check_val({ph, ".perf_fetch"}, perf_fetch_cnt, m_fetches);
        check_val({ph, ".perf_bubble"}, perf_bubble_cnt, m_bubbles);
`endif
    endtask

    task automatic step(input string ph, input logic fz, input logic br, input logic [31:0] ba);
        @(negedge clk);
        bus.freeze = fz; bus.branch_taken = br; bus.branch_addr = ba;
        @(posedge clk);
        cyc++;
        model_clock(fz, br, ba);
        #1;
        compare_all(ph);
        $display("cyc %0d %s fz=%b br=%b ba=%h -> pc=%h id_pc=%h id_valid=%b halted=%b",
                 cyc, ph, fz, br, ba, bus.imem_addr, bus.id_pc, bus.id_valid, bus.halted);
    endtask

    task automatic release_reset(input string ph);
        @(negedge clk);
        rst = 1'b1; bus.freeze = 1'b0; bus.branch_taken = 1'b0;
        @(posedge clk);
        cyc++;
        model_clock(1'b0, 1'b0, 32'h0);
        #1;
        compare_all(ph);
        $display("cyc %0d %s reset released (BOOT) -> pc=%h id_valid=%b",
                 cyc, ph, bus.imem_addr, bus.id_valid);
    endtask

    // Drops rst between clock edges and checks the outputs clear without a clock.
    task automatic async_reset(input string ph);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all(ph);
        $display("cyc %0d %s async reset asserted -> pc=%h id_valid=%b",
                 cyc, ph, bus.imem_addr, bus.id_valid);
        @(posedge clk);
        release_reset({ph, "_boot"});
    endtask

    initial begin
        logic        fz, br;
        logic [31:0] ba;
        bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        release_reset("boot");
        check_val("boot_no_fetch", {31'b0, bus.id_valid}, 32'h0);

        step("run", 1'b0, 1'b0, 32'h0);
        check_val("first_id_pc", bus.id_pc, 32'h4);
        step("run", 1'b0, 1'b0, 32'h0);
        repeat (3) step("freeze", 1'b1, 1'b0, 32'h0);
        check_val("freeze_pc", bus.imem_addr, 32'h8);
        step("resume", 1'b0, 1'b0, 32'h0);
        check_val("resume_pc", bus.imem_addr, 32'hC);

        step("branch", 1'b0, 1'b1, 32'h0000_0103);
        check_val("branch_pc", bus.imem_addr, 32'h100);
        step("post_branch", 1'b0, 1'b0, 32'h0);
        check_val("post_branch_id_pc", bus.id_pc, 32'h104);

        step("frz_br", 1'b1, 1'b1, 32'h0000_0008);
        check_val("frz_br_valid", {31'b0, bus.id_valid}, 32'h0);

        for (int i = 0; i < 20 && m_state != M_HALT; i++) step("to_halt", 1'b0, 1'b0, 32'h0);
        check_val("halt_reached", {31'b0, bus.halted}, 32'h1);
        check_val("halt_pc", bus.imem_addr, PC_LIMIT);
        repeat (2) step("halt", 1'b0, 1'b0, 32'h0);
        step("halt_frz", 1'b1, 1'b0, 32'h0);
        step("unhalt", 1'b0, 1'b1, 32'h0);
        check_val("unhalt", {31'b0, bus.halted}, 32'h0);

        for (int i = 0; i < 20 && m_pc != 32'h10; i++) step("to_10", 1'b0, 1'b0, 32'h0);
        check_val("at_10", bus.imem_addr, 32'h10);
        async_reset("areset");

        step("wrap_br", 1'b0, 1'b1, 32'hFFFF_FFFE);
        step("wrap", 1'b0, 1'b0, 32'h0);
        check_val("wrap_pc", bus.imem_addr, 32'h0);
        check_val("wrap_instr", bus.id_instr, mem_word(32'hFFFF_FFFC));

        for (int i = 0; i < 400; i++) begin
            fz = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) ba = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else                           ba = 32'($urandom_range(0, 32'h1B));
            step("rand", fz, br, ba);
            if (i == 200) async_reset("rand_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
